// File: rtl/systolic_array_nxn_if.sv
// systolic_array_nxn_if: job control, operand stream and result drain of systolic_array_nxn
interface systolic_array_nxn_if #(
  parameter int N  = 2,
  parameter int DW = 16,
  parameter int AW = 32,
  parameter int KW = 8
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_col;
  logic [N*DW-1:0] b_row;
  logic            busy;
  logic            out_valid;
  logic [IW-1:0]   out_idx;
  logic [N*AW-1:0] out_row;
  logic            done;
  modport master (
    output start, k_len, in_valid, a_col, b_row,
    input  in_ready, busy, out_valid, out_idx, out_row, done
  );
  modport slave (
    input  start, k_len, in_valid, a_col, b_row,
    output in_ready, busy, out_valid, out_idx, out_row, done
  );
endinterface

// File: rtl/systolic_array_nxn.sv
// systolic_array_nxn: N x N output-stationary signed matrix multiplier with input skew and row-per-cycle drain
module systolic_array_nxn #(
  parameter int N  = 2,
  parameter int DW = 16,
  parameter int AW = 32,
  parameter int KW = 8
) (
  input logic                 clk,
  input logic                 reset,
  systolic_array_nxn_if.slave bus
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int CW = KW > IW + 1 ? KW : IW + 1;
  localparam int PW = 2 * DW;
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic in_ready_q, busy_q, out_valid_q, done_q;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic [N*AW-1:0] out_row_q, out_row_d;
  logic clr, feed;
  logic signed [DW-1:0] a_sk_q [N][N], a_sk_d [N][N], b_sk_q [N][N], b_sk_d [N][N];
  logic signed [DW-1:0] a_q [N][N], a_d [N][N], b_q [N][N], b_d [N][N];
  logic signed [AW-1:0] acc_q [N][N], acc_d [N][N];
  assign clr  = state_q == IDLE && bus.start;
  assign feed = state_q == FEED && bus.in_valid;
  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_row   = out_row_q;
  assign bus.done      = done_q;
  always_comb begin
    a_sk_d = '{default: '0};
    b_sk_d = '{default: '0};
    a_d    = '{default: '0};
    b_d    = '{default: '0};
    acc_d  = '{default: '0};
    for (int i = 0; i < N; i++) begin
      a_sk_d[i][0] = feed ? bus.a_col[i*DW +: DW] : '0;
      b_sk_d[i][0] = feed ? bus.b_row[i*DW +: DW] : '0;
      for (int s = 1; s < N; s++) begin
        a_sk_d[i][s] = a_sk_q[i][s-1];
        b_sk_d[i][s] = b_sk_q[i][s-1];
      end
      a_d[i][0] = a_sk_d[i][i];
      b_d[0][i] = b_sk_d[i][i];
      for (int s = 1; s < N; s++) begin
        a_d[i][s] = a_q[i][s-1];
        b_d[s][i] = b_q[s-1][i];
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        acc_d[i][j] = acc_q[i][j] + AW'(PW'(a_d[i][j]) * PW'(b_d[i][j]));
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        state_d = bus.start ? (bus.k_len == '0 ? DRAIN : FEED) : IDLE;
        k_d     = bus.start ? bus.k_len : k_q;
        cnt_d   = '0;
      end
      FEED: if (bus.in_valid) begin
        state_d = cnt_q + 1'b1 == CW'(k_q) ? (N == 1 ? DRAIN : FLUSH) : FEED;
        cnt_d   = state_d == FEED ? cnt_q + 1'b1 : '0;
      end
      FLUSH: begin
        state_d = cnt_q == CW'(2 * N - 3) ? DRAIN : FLUSH;
        cnt_d   = state_d == FLUSH ? cnt_q + 1'b1 : '0;
      end
      default: begin
        state_d = cnt_q == CW'(N - 1) ? IDLE : DRAIN;
        cnt_d   = cnt_q + 1'b1;
      end
    endcase
    out_idx_d = state_d == DRAIN ? IW'(cnt_d) : '0;
    out_row_d = '0;
    for (int j = 0; j < N; j++)
      out_row_d[j*AW +: AW] = state_d == DRAIN && !clr ? acc_d[out_idx_d][j] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_row_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      in_ready_q  <= state_d == FEED;
      busy_q      <= state_d != IDLE;
      out_valid_q <= state_d == DRAIN;
      out_idx_q   <= out_idx_d;
      out_row_q   <= out_row_d;
      done_q      <= state_q == DRAIN && state_d == IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      a_sk_q <= '{default: '0};
      b_sk_q <= '{default: '0};
      a_q    <= '{default: '0};
      b_q    <= '{default: '0};
      acc_q  <= '{default: '0};
    end else begin
      a_sk_q <= a_sk_d;
      b_sk_q <= b_sk_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
    end
  end
endmodule

// File: tb/tb_systolic_array_nxn.sv
// tb_systolic_array_nxn: randomized scoreboard bench comparing drained rows and timing against a matrix-product model
module tb_systolic_array_nxn;
  localparam int N = 4, DW = 16, AW = 32, KW = 8, KMAX = 8;
  typedef struct {
    int              cyc;
    int              idx;
    logic [N*AW-1:0] row;
  } row_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  row_t exp_rows[$];
  int   exp_done[$];
  int   checks = 0, passes = 0, ncyc = 0;
  int   am [N][KMAX];
  int   bm [KMAX][N];
  int   gaps [KMAX];
  systolic_array_nxn_if #(.N(N), .DW(DW), .AW(AW), .KW(KW)) bus ();
  systolic_array_nxn #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic void check(string name, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction
  function automatic void check_idle(string name);
    check(name, {bus.in_ready, bus.busy, bus.out_valid, bus.out_idx, bus.done, bus.out_row}, '0);
  endfunction
  always @(negedge clk) begin : monitor
    row_t e;
    ncyc++;
    if (bus.out_valid) begin
      if (exp_rows.size() == 0) check("unexpected_row", bus.out_valid, 0);
      else begin
        e = exp_rows.pop_front();
        check("row_idx", bus.out_idx, e.idx);
        check("row_data", bus.out_row, e.row);
        check("row_cycle", ncyc, e.cyc);
        check("row_busy", bus.busy, 1);
      end
    end
    if (bus.done) begin
      if (exp_done.size() == 0) check("unexpected_done", bus.done, 0);
      else begin
        check("done_cycle", ncyc, exp_done.pop_front());
        check("done_busy", bus.busy, 0);
      end
    end
  end
  task automatic clear_job();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        am[i][k] = 0;
        bm[k][i] = 0;
      end
    for (int k = 0; k < KMAX; k++) gaps[k] = 0;
  endtask
  task automatic set_basic();
    clear_job();
    am[0][0] = 1; am[0][1] = 2; am[1][0] = 3; am[1][1] = 4;
    bm[0][0] = 5; bm[0][1] = 6; bm[1][0] = 7; bm[1][1] = 8;
  endtask
  task automatic wait_done();
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      if (bus.done) return;
    end
    check("done_timeout", bus.done, 1);
  endtask
  task automatic run_job(input int k, input bit abort, input bit poke_start);
    int s, g, first;
    longint sum;
    row_t r;
    g = 0;
    for (int kk = 0; kk < k; kk++) g += gaps[kk];
    bus.k_len = KW'(k);
    bus.start = 1'b1;
    @(posedge clk);
    s = ncyc;
    #1 bus.start = 1'b0;
    if (!abort) begin
      first = k == 0 ? 1 : k + g + 2 * N - 1;
      for (int i = 0; i < N; i++) begin
        r.cyc = s + first + i;
        r.idx = i;
        r.row = '0;
        for (int j = 0; j < N; j++) begin
          sum = 0;
          for (int kk = 0; kk < k; kk++) sum += longint'(am[i][kk]) * longint'(bm[kk][j]);
          r.row[j*AW +: AW] = sum[AW-1:0];
        end
        exp_rows.push_back(r);
      end
      exp_done.push_back(s + first + N);
    end
    for (int kk = 0; kk < k; kk++) begin
      repeat (gaps[kk]) begin
        bus.in_valid = 1'b0;
        check("gap_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
      end
      if (abort && kk == 2) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("abort_reset");
        return;
      end
      bus.in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        bus.a_col[i*DW +: DW] = am[i][kk][DW-1:0];
        bus.b_row[i*DW +: DW] = bm[kk][i][DW-1:0];
      end
      check("in_ready", bus.in_ready, 1);
      if (poke_start && kk == 0) begin
        bus.start = 1'b1;
        bus.k_len = '0;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
    end
    wait_done();
  endtask
  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction
  initial begin
    int k;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.in_valid = 1'b0;
    bus.a_col = '0;
    bus.b_row = '0;
    repeat (3) @(posedge clk);
    #1 check_idle("reset_values");
    reset = 1'b0;
    @(posedge clk); #1;
    set_basic();
    run_job(2, 0, 0);
    @(posedge clk); #1;
    set_basic();
    gaps[1] = 3;
    run_job(2, 0, 0);
    @(posedge clk); #1;
    set_basic();
    run_job(2, 0, 0);
    clear_job();
    am[0][0] = 1; am[1][0] = 1; bm[0][0] = 2; bm[0][1] = 2;
    run_job(1, 0, 0);
    @(posedge clk); #1;
    clear_job();
    for (int i = 0; i < N; i++) begin
      am[i][i] = 1;
      for (int j = 0; j < N; j++) bm[i][j] = rnd16();
    end
    bm[0][0] = -32768;
    bm[1][1] = 32767;
    bm[2][3] = -1;
    run_job(4, 0, 0);
    @(posedge clk); #1;
    run_job(0, 0, 0);
    @(posedge clk); #1;
    clear_job();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < 3; kk++) begin
        am[i][kk] = rnd16();
        bm[kk][i] = rnd16();
      end
    run_job(3, 0, 1);
    @(posedge clk); #1;
    clear_job();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < 5; kk++) begin
        am[i][kk] = 7;
        bm[kk][i] = 9;
      end
    run_job(5, 1, 0);
    repeat (3 * N + 10) @(posedge clk);
    #1 check_idle("post_abort_idle");
    clear_job();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < 3; kk++) begin
        am[i][kk] = -32768;
        bm[kk][i] = -32768;
      end
    run_job(3, 0, 0);
    for (int n = 0; n < 15; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
      clear_job();
      k = int'($urandom_range(1, 6));
      for (int kk = 0; kk < k; kk++) begin
        gaps[kk] = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0;
        for (int i = 0; i < N; i++) begin
          am[i][kk] = rnd16();
          bm[kk][i] = rnd16();
        end
      end
      run_job(k, 0, 0);
    end
    for (int t = 0; t < 100 && (exp_rows.size() + exp_done.size()) != 0; t++) @(posedge clk);
    #1 check("queues_drained", exp_rows.size() + exp_done.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
